modulo_gerenciador_rolhas_param: RTL and testbench

MODULO_GERENCIADOR_ROLHAS_PARAM -- requirements
Module: modulo_gerenciador_rolhas_param

---
 rtl/pkg_rolhas.sv | 23 ++
 rtl/modulo_contador_sync_param_ascendente_descendente.sv | 34 +++
 rtl/modulo_gerenciador_rolhas_param.sv | 215 +++++++++++++++++++++
 tb/tb_modulo_gerenciador_rolhas_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_rolhas.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_rolhas
//  Description : Shared definitions for the cork buffer manager: FSM state
//                encodings and default capacity/threshold values.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_rolhas;

    // Fixed state encoding; code 2'b11 is illegal and recovers to OCIOSO
    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        CARGA_OP  = 2'b01,
        TRANSFERE = 2'b10
    } estado_t;

    localparam int MAX_SEC_DEF = 99;
    localparam int MAX_PRI_DEF = 30;
    localparam int LOTE_DEF    = 20;
    localparam int MIN_PRI_DEF = 5;

endpackage
`default_nettype wire

// File: rtl/modulo_contador_sync_param_ascendente_descendente.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_contador_sync_param_ascendente_descendente
//  Description : Parameterised up/down counter with synchronous parallel
//                load and asynchronous active-low clear. Load wins over count.
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_contador_sync_param_ascendente_descendente #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] load,
    input  logic             e_load,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Count register: clear, then load, then count up (up_down=1) or down
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (e_load) begin
            q <= load;
        end else if (enable) begin
            q <= up_down ? (q + ONE) : (q - ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/modulo_gerenciador_rolhas_param.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_gerenciador_rolhas_param
//  Description : Two-level cork buffer manager. Operator loads fill the
//                secondary buffer one cork per cycle; the primary buffer is
//                refilled from the secondary in batches when it runs low;
//                sealing consumes corks from the primary buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_gerenciador_rolhas_param
    import pkg_rolhas::*;
#(
    parameter int W_SEC   = 7,
    parameter int W_PRI   = 5,
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int MAX_PRI = MAX_PRI_DEF,
    parameter int LOTE    = LOTE_DEF,
    parameter int MIN_PRI = MIN_PRI_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             op_load,
    input  logic [W_SEC-1:0] op_qtd,
    input  logic             consumo,
    output logic [W_SEC-1:0] sec_count,
    output logic [W_PRI-1:0] pri_count,
    output logic             ro,
    output logic             busy,
    output logic             rejeitado,
    output logic [1:0]       estado
);

    // Remaining-cycles counter must hold either an operator quantity or a batch
    localparam int W_REM = (W_SEC > W_PRI) ? W_SEC : W_PRI;
    localparam int W_CMP = W_REM + 1;
    localparam logic [W_REM-1:0] REM_ONE = W_REM'(1);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (MAX_SEC >= (1 << W_SEC)) begin : g_chk_max_sec
        $error("MAX_SEC does not fit in W_SEC bits");
    end
    if (MAX_PRI >= (1 << W_PRI)) begin : g_chk_max_pri
        $error("MAX_PRI does not fit in W_PRI bits");
    end
    if (!((MIN_PRI > 0) && (MIN_PRI <= LOTE) && (LOTE <= MAX_PRI))) begin : g_chk_thresholds
        $error("need 0 < MIN_PRI <= LOTE <= MAX_PRI");
    end

    estado_t          state;
    estado_t          next_state;
    logic [W_REM-1:0] remaining;
    logic [W_REM-1:0] rem_load;
    logic             rem_load_en;
    logic             rem_dec;
    logic             sec_en;
    logic             sec_up;
    logic             pri_en;
    logic             pri_up;
    logic             reject_next;
    logic             start_xfer;
    logic             load_ok;
    logic             consume_ok;
    logic [W_SEC:0]   sec_sum;
    logic [W_CMP-1:0] batch;

    // Refill is due when the primary is below threshold and corks are available
    assign start_xfer = (pri_count < W_PRI'(MIN_PRI)) && (sec_count != '0);
    // Overflow check carried in one extra bit so the sum cannot wrap
    assign sec_sum    = {1'b0, sec_count} + {1'b0, op_qtd};
    assign load_ok    = (op_qtd != '0) && (sec_sum <= (W_SEC + 1)'(MAX_SEC));
    assign consume_ok = consumo && (pri_count != '0);

    // Batch size = min(LOTE, sec_count, free space in primary)
    always_comb begin
        batch = W_CMP'(LOTE);
        if (W_CMP'(sec_count) < batch) begin
            batch = W_CMP'(sec_count);
        end
        if ((W_CMP'(MAX_PRI) - W_CMP'(pri_count)) < batch) begin
            batch = W_CMP'(MAX_PRI) - W_CMP'(pri_count);
        end
    end

    // Next-state and counter control; nothing moves while enable is low
    always_comb begin
        next_state  = state;
        rem_load_en = 1'b0;
        rem_load    = '0;
        rem_dec     = 1'b0;
        sec_en      = 1'b0;
        sec_up      = 1'b0;
        pri_en      = 1'b0;
        pri_up      = 1'b0;
        reject_next = 1'b0;
        if (enable) begin
            case (state)
                OCIOSO: begin
                    if (start_xfer) begin
                        // Refill beats any simultaneous operator load
                        next_state  = TRANSFERE;
                        rem_load_en = 1'b1;
                        rem_load    = W_REM'(batch);
                        reject_next = op_load;
                    end else if (op_load) begin
                        if (load_ok) begin
                            next_state  = CARGA_OP;
                            rem_load_en = 1'b1;
                            rem_load    = W_REM'(op_qtd);
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                    pri_en = consume_ok;
                end
                CARGA_OP: begin
                    reject_next = op_load;
                    if (remaining != '0) begin
                        sec_en  = 1'b1;
                        sec_up  = 1'b1;
                        rem_dec = 1'b1;
                    end
                    if (remaining <= REM_ONE) begin
                        next_state = OCIOSO;
                    end
                    pri_en = consume_ok;
                end
                TRANSFERE: begin
                    reject_next = op_load;
                    if (remaining != '0) begin
                        sec_en  = 1'b1;
                        rem_dec = 1'b1;
                        // A simultaneous consumption cancels this cycle's increment
                        pri_en  = !consumo;
                        pri_up  = 1'b1;
                    end else begin
                        pri_en = consume_ok;
                    end
                    if (remaining <= REM_ONE) begin
                        next_state = OCIOSO;
                    end
                end
                default: begin
                    // Illegal code: recover to idle and drop any leftover count
                    next_state  = OCIOSO;
                    rem_load_en = 1'b1;
                    reject_next = op_load;
                    pri_en      = consume_ok;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= OCIOSO;
        end else begin
            state <= next_state;
        end
    end

    // Registered refusal pulse, one cycle after the offending request
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rejeitado <= 1'b0;
        end else begin
            rejeitado <= reject_next;
        end
    end

    modulo_contador_sync_param_ascendente_descendente #(
        .WIDTH (W_SEC)
    ) u_sec (
        .clk     (clk),
        .clr     (clr),
        .enable  (sec_en),
        .up_down (sec_up),
        .load    ('0),
        .e_load  (1'b0),
        .q       (sec_count)
    );

    modulo_contador_sync_param_ascendente_descendente #(
        .WIDTH (W_PRI)
    ) u_pri (
        .clk     (clk),
        .clr     (clr),
        .enable  (pri_en),
        .up_down (pri_up),
        .load    ('0),
        .e_load  (1'b0),
        .q       (pri_count)
    );

    modulo_contador_sync_param_ascendente_descendente #(
        .WIDTH (W_REM)
    ) u_rem (
        .clk     (clk),
        .clr     (clr),
        .enable  (rem_dec),
        .up_down (1'b0),
        .load    (rem_load),
        .e_load  (rem_load_en),
        .q       (remaining)
    );

    assign ro     = (pri_count == '0);
    assign busy   = (state != OCIOSO);
    assign estado = state;

endmodule
`default_nettype wire

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_modulo_gerenciador_rolhas_param
//  Description : Self-checking bench for the cork buffer manager: directed
//                vector table, scenario sequences and randomized traffic
//                against a job-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_gerenciador_rolhas_param;

    localparam int W_SEC   = 7;
    localparam int W_PRI   = 5;
    localparam int MAX_SEC = 99;
    localparam int MAX_PRI = 30;
    localparam int LOTE    = 20;
    localparam int MIN_PRI = 5;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             enable = 1'b0;
    logic             op_load = 1'b0;
    logic [W_SEC-1:0] op_qtd = '0;
    logic             consumo = 1'b0;
    logic [W_SEC-1:0] sec_count;
    logic [W_PRI-1:0] pri_count;
    logic             ro;
    logic             busy;
    logic             rejeitado;
    logic [1:0]       estado;

    modulo_gerenciador_rolhas_param #(
        .W_SEC   (W_SEC),
        .W_PRI   (W_PRI),
        .MAX_SEC (MAX_SEC),
        .MAX_PRI (MAX_PRI),
        .LOTE    (LOTE),
        .MIN_PRI (MIN_PRI)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .enable    (enable),
        .op_load   (op_load),
        .op_qtd    (op_qtd),
        .consumo   (consumo),
        .sec_count (sec_count),
        .pri_count (pri_count),
        .ro        (ro),
        .busy      (busy),
        .rejeitado (rejeitado),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: buffer levels plus the current job (0 none, 1 load, 2 refill)
    int m_sec, m_pri, m_job, m_left;
    bit m_rej;

    task automatic model_reset();
        m_sec = 0; m_pri = 0; m_job = 0; m_left = 0; m_rej = 1'b0;
    endtask

    task automatic model_edge();
        bit rej;
        rej = 1'b0;
        if (!enable) begin
            m_rej = 1'b0;
            return;
        end
        if (m_job == 0) begin
            if (m_pri < MIN_PRI && m_sec > 0) begin
                m_job  = 2;
                m_left = LOTE;
                if (m_sec < m_left) m_left = m_sec;
                if (MAX_PRI - m_pri < m_left) m_left = MAX_PRI - m_pri;
                rej = op_load;
            end else if (op_load) begin
                if (op_qtd != 0 && m_sec + int'(op_qtd) <= MAX_SEC) begin
                    m_job  = 1;
                    m_left = int'(op_qtd);
                end else begin
                    rej = 1'b1;
                end
            end
            if (consumo && m_pri > 0) m_pri--;
        end else if (m_job == 1) begin
            rej = op_load;
            m_sec++;
            m_left--;
            if (m_left == 0) m_job = 0;
            if (consumo && m_pri > 0) m_pri--;
        end else begin
            rej = op_load;
            m_sec--;
            if (!consumo) m_pri++;
            m_left--;
            if (m_left == 0) m_job = 0;
        end
        m_rej = rej;
    endtask

    task automatic check_outputs(string name);
        logic [16:0] act, exp;
        act = {sec_count, pri_count, ro, busy, rejeitado, estado};
        exp = {7'(m_sec), 5'(m_pri), (m_pri == 0), (m_job != 0), m_rej, 2'(m_job)};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got sec=%0d pri=%0d ro=%0b busy=%0b rej=%0b est=%0d, want sec=%0d pri=%0d ro=%0b busy=%0b rej=%0b est=%0d",
                     name, sec_count, pri_count, ro, busy, rejeitado, estado,
                     m_sec, m_pri, (m_pri == 0), (m_job != 0), m_rej, m_job);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(bit en, bit ld, int q, bit cs);
        enable  = en;
        op_load = ld;
        op_qtd  = W_SEC'(q);
        consumo = cs;
    endtask

    // One clock: inputs stable across the edge, outputs sampled 1 ns after it
    task automatic step(string name);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(name);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0);
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clk);
        #3;
        clr    = 1'b1;
        enable = 1'b1;
    endtask

    task automatic load_and_run(int q, int n, string name);
        drive(1'b1, 1'b1, q, 1'b0);
        step(name);
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (n) step(name);
    endtask

    typedef struct {
        bit en;
        bit ld;
        int qtd;
        bit cs;
        int sec;
        int pri;
        int est;
        bit rej;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int busy_cnt;

        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 1};  // zero quantity refused
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 3, 0, 0, 0, 0, 0};  // disabled: load ignored
        tbl[3]  = '{1, 1, 3, 0, 0, 0, 1, 0};  // load of 3 accepted
        tbl[4]  = '{1, 1, 5, 0, 1, 0, 1, 1};  // refused while busy
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 1, 0};  // hold
        tbl[6]  = '{1, 0, 0, 0, 2, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 3, 0, 0, 0};  // load done
        tbl[8]  = '{1, 1, 2, 0, 3, 0, 2, 1};  // refill wins over load
        tbl[9]  = '{1, 0, 0, 0, 2, 1, 2, 0};
        tbl[10] = '{1, 0, 0, 1, 1, 1, 2, 0};  // consumo cancels increment
        tbl[11] = '{1, 0, 0, 0, 0, 2, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 1, 0, 0, 0, 0};  // no wrap below zero

        // ---------------- vector table ----------------
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].qtd, tbl[i].cs);
            step("tbl_model");
            tests++;
            if (sec_count !== W_SEC'(tbl[i].sec) || pri_count !== W_PRI'(tbl[i].pri) ||
                estado !== 2'(tbl[i].est) || rejeitado !== tbl[i].rej ||
                ro !== (tbl[i].pri == 0)) begin
                fails++;
                $display("FAIL tbl[%0d]: got sec=%0d pri=%0d est=%0d rej=%0b ro=%0b, want sec=%0d pri=%0d est=%0d rej=%0b",
                         i, sec_count, pri_count, estado, rejeitado, ro,
                         tbl[i].sec, tbl[i].pri, tbl[i].est, tbl[i].rej);
            end
        end

        // ---------------- load 50 then refill 20 ----------------
        do_reset();
        drive(1'b1, 1'b1, 50, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 51; i++) begin
            step("load50");
            drive(1'b1, 1'b0, 0, 1'b0);
            if (busy) busy_cnt++;
        end
        check_val("load50_busy_cycles", busy_cnt, 50);
        check_val("load50_sec", int'(sec_count), 50);
        repeat (21) step("refill20");
        check_val("refill20_sec", int'(sec_count), 30);
        check_val("refill20_pri", int'(pri_count), 20);
        check_val("refill20_ro", int'(ro), 0);

        // ---------------- overflow refusal at sec=95 ----------------
        load_and_run(65, 65, "load65");
        check_val("pre_ovf_sec", int'(sec_count), 95);
        drive(1'b1, 1'b1, 10, 1'b0);
        step("ovf");
        check_val("ovf_rej", int'(rejeitado), 1);
        check_val("ovf_sec", int'(sec_count), 95);
        check_val("ovf_est", int'(estado), 0);
        drive(1'b1, 1'b0, 0, 1'b0);
        step("ovf_after");
        check_val("ovf_rej_one_cycle", int'(rejeitado), 0);

        // ---------------- partial refill of 7 ----------------
        do_reset();
        load_and_run(7, 7, "load7");
        repeat (8) step("partial7");
        check_val("partial7_pri", int'(pri_count), 7);
        check_val("partial7_sec", int'(sec_count), 0);
        repeat (3) step("partial7_idle");
        check_val("partial7_est", int'(estado), 0);

        // ---------------- pri=4, sec=40, consumo mid-refill ----------------
        do_reset();
        load_and_run(4, 4, "load4");
        repeat (5) step("refill4");
        load_and_run(40, 40, "load40");
        check_val("pre_refill_pri", int'(pri_count), 4);
        check_val("pre_refill_sec", int'(sec_count), 40);
        step("refill_start");
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 0, (i >= 8 && i < 11));
            step("refill_consumo");
        end
        check_val("refill_consumo_pri", int'(pri_count), 21);
        check_val("refill_consumo_sec", int'(sec_count), 20);
        check_val("refill_consumo_est", int'(estado), 0);

        // ---------------- async reset mid-refill ----------------
        do_reset();
        load_and_run(40, 40, "load40b");
        step("refill_b_start");
        repeat (10) step("refill_b");
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_outputs("async_clr");
        #4;
        clr = 1'b1;
        repeat (3) step("after_clr");
        check_val("after_clr_est", int'(estado), 0);

        // ---------------- consumo on empty primary ----------------
        do_reset();
        drive(1'b1, 1'b0, 0, 1'b1);
        repeat (5) step("empty_consumo");
        check_val("empty_pri", int'(pri_count), 0);
        check_val("empty_ro", int'(ro), 1);

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 11) == 0,
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 40)),
                  $urandom_range(0, 3) == 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
